keyboard_decoder: RTL and testbench
===================================

// Module: keyboard_decoder
// PURPOSE
// - PS/2 keyboard front end. Receives raw PS/2 frames (scan-code set 2) and drives the 3-bit key code that game_menu consumes on keyboard_in.
// - Sits between the board PS/2 pins and game_menu / race logic in the top level. Uses the single pixel-clock domain.
// PARAMETERS
// - FILTER_LEN    8      ps2_clk glitch filter: consecutive equal synced samples required before the filtered level changes
// - TIMEOUT_CYCLES 65000  clk cycles with no filtered falling edge mid-frame before the frame is aborted (~1 ms at 65 MHz)
// PORTS
// - clk           in   1  system/pixel clock
// - rst           in   1  synchronous, active-high reset
// - ps2_clk       in   1  raw PS/2 clock, asynchronous
// - ps2_data      in   1  raw PS/2 data, asynchronous
// - keyboard_out  out  3  held key code; connects to game_menu keyboard_in
// - key_valid     out  1  one-cycle pulse on each accepted make (press) code
// - frame_error   out  1  one-cycle pulse on a bad start/stop/parity bit or a timeout
// BEHAVIOUR
// - Sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. ps2_clk then passes the FILTER_LEN filter; the filtered level resets to 1.
// - fall = filtered ps2_clk 1->0. ps2_data is sampled only on fall.
// - Receive FSM, states IDLE, DATA, PARITY, STOP:
//   - IDLE: on fall with data=0 (start bit), clear the bit counter and go to DATA. On fall with data=1, stay in IDLE with no error.
//   - DATA: shift in LSB first. After the 8th bit, go to PARITY.
//   - PARITY: store the bit, go to STOP.
//   - STOP: on fall, go to IDLE. byte_rdy pulses the next cycle if stop=1 and the parity check passes; otherwise frame_error pulses and the byte is dropped.
//   - Timeout: a watchdog counter clears on every fall and counts while not in IDLE. At TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, discard partial data. The ext/brk flags are kept.
// - Byte decoder, with flags ext and brk:
//   - E0 sets ext. F0 sets brk. Neither prefix produces an output.
//   - Any other byte: look up code(ext, byte), then clear both ext and brk.
//   - Code map, all others map to 000 (ignored):
//     - 001 UP     = E0 75
//     - 010 DOWN   = E0 72
//     - 011 ENTER  = 5A
//     - 100 ESC    = 76
//     - 101 SPACE  = 29
//     - 110 LEFT   = E0 6B
//     - 111 RIGHT  = E0 74
//   - Make (brk=0) with nonzero code: keyboard_out <= code and key_valid pulses.
//   - Break (brk=1) with nonzero code: keyboard_out <= 000 only if it equals that code; otherwise unchanged. key_valid does not pulse.
//   - Typematic repeats (the same make code again) re-pulse key_valid and keep keyboard_out unchanged.
// - Latency: fall on the stop bit at cycle N -> byte_rdy at N+1 -> keyboard_out and key_valid at N+2.
// - Simultaneous events: a new press overrides the held code (last key wins). A release of a non-held key is ignored.
// - Reset, including mid-frame:
//   - FSM goes to IDLE; shift register, ext, brk and watchdog are cleared.
//   - keyboard_out=000, key_valid=0, frame_error=0.
//   - The filtered ps2_clk level is forced to 1, so no spurious fall occurs after reset.
// CONFIGURATION
// - KEYBOARD_PARITY_CHECK_EN defined: odd parity over data+parity is required. A mismatch drops the byte and pulses frame_error.
// - KEYBOARD_PARITY_CHECK_EN undefined: the parity bit is received but ignored. Only the stop bit and the timeout can raise frame_error.
// TESTING
// - Reset, then send frame 5A (bits 0,01011010 LSB-first, parity 1, stop 1) -> keyboard_out=011 and one key_valid pulse at N+2.
// - Send E0,75 -> keyboard_out=001. Then E0,F0,75 -> keyboard_out=000, no key_valid on the break.
// - Hold DOWN (E0 72), press SPACE (29), release DOWN (E0 F0 72) -> keyboard_out=010, then 101, stays 101.
// - With KEYBOARD_PARITY_CHECK_EN: frame 5A with parity 0 -> frame_error pulse, keyboard_out unchanged. Without the macro: keyboard_out=011.
// - Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_error pulse, FSM back to IDLE. The next full 76 frame -> keyboard_out=100.
// - Assert rst for 1 cycle mid-frame of 29, then send a full 5A frame -> the partial frame is discarded and keyboard_out=011.
// - Inject 3-cycle ps2_clk glitches (< FILTER_LEN) during IDLE -> no state change and no frame_error.

Source files
------------

// File: rtl/keyboard_decoder_if.sv
// keyboard_decoder_if: PS/2 pin inputs and decoded key outputs of keyboard_decoder
interface keyboard_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] keyboard_out;
    logic       key_valid;
    logic       frame_error;
    modport master (output ps2_clk, ps2_data, input keyboard_out, key_valid, frame_error);
    modport slave  (input ps2_clk, ps2_data, output keyboard_out, key_valid, frame_error);
endinterface

// File: rtl/keyboard_decoder.sv
// keyboard_decoder: PS/2 set-2 receiver and key decoder producing a held 3-bit game key code
// Optional KEYBOARD_PARITY_CHECK_EN: enforce odd parity on received frames
module keyboard_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input logic clk,
    input logic rst,
    keyboard_decoder_if.slave kb
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [1:0] clk_sync, data_sync;
    logic [FW-1:0] filt_cnt;
    logic filt, filt_q, fall, din;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic par_bit, parity_ok, frame_ok, byte_done, timeout, byte_rdy, err;
    logic [WW-1:0] wdog;
    logic ext, brk, key_valid, is_prefix;
    logic [2:0] kout, code;
    logic [8:0] key;
    assign fall = filt_q & ~filt;
    assign din = data_sync[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            data_sync <= 2'b11;
            filt_cnt <= '0;
            filt <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], kb.ps2_clk};
            data_sync <= {data_sync[0], kb.ps2_data};
            filt_q <= filt;
            if (clk_sync[1] == filt)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end
    end
`ifdef KEYBOARD_PARITY_CHECK_EN
    assign parity_ok = ^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = din & parity_ok;
    assign byte_done = fall && state == STOP;
    always_comb begin
        timeout = state != IDLE && !fall && wdog == WW'(TIMEOUT_CYCLES - 1);
        state_n = timeout ? IDLE
                : !fall ? state
                : state == IDLE ? (din ? IDLE : DATA)
                : state == DATA ? (bit_cnt == 3'd7 ? PARITY : DATA)
                : state == PARITY ? STOP
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            shift <= '0;
            par_bit <= 1'b0;
            wdog <= '0;
            byte_rdy <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            wdog <= (fall || state == IDLE) ? '0 : wdog + 1'b1;
            bit_cnt <= state == IDLE ? 3'd0 : (fall && state == DATA) ? bit_cnt + 3'd1 : bit_cnt;
            shift <= timeout ? 8'd0 : (fall && state == DATA) ? {din, shift[7:1]} : shift;
            par_bit <= (fall && state == PARITY) ? din : par_bit;
            byte_rdy <= byte_done && frame_ok;
            err <= timeout || (byte_done && !frame_ok);
        end
    end
    // shift still holds the completed byte while byte_rdy is high
    always_comb begin
        key = {ext, shift};
        is_prefix = shift == 8'hE0 || shift == 8'hF0;
        code = key == 9'h175 ? 3'd1
             : key == 9'h172 ? 3'd2
             : key == 9'h05A ? 3'd3
             : key == 9'h076 ? 3'd4
             : key == 9'h029 ? 3'd5
             : key == 9'h16B ? 3'd6
             : key == 9'h174 ? 3'd7
             : 3'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
            kout <= 3'd0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= byte_rdy && !is_prefix && !brk && code != 3'd0;
            if (byte_rdy) begin
                if (shift == 8'hE0)
                    ext <= 1'b1;
                else if (shift == 8'hF0)
                    brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (code != 3'd0 && !brk)
                        kout <= code;
                    else if (code != 3'd0 && kout == code)
                        kout <= 3'd0;
                end
            end
        end
    end
    assign kb.keyboard_out = kout;
    assign kb.key_valid = key_valid;
    assign kb.frame_error = err;
endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder: randomized PS/2 frames against a key-level reference model with event scoreboard
module tb_keyboard_decoder;
    localparam int TMO  = 500;
    localparam int HALF = 15;
    localparam int GAP  = 40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    keyboard_decoder_if kbif ();
    keyboard_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .kb(kbif));
    always #5 clk = ~clk;
    typedef struct {bit is_err; logic [2:0] code;} exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;
    logic [2:0] held = 3'd0;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    logic [8:0] keys [7] = '{9'h175, 9'h172, 9'h05A, 9'h076, 9'h029, 9'h16B, 9'h174};
    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h5A, 8'h76, 8'h29, 8'h6B, 8'h74, 8'h00};
`ifdef KEYBOARD_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Key-level behaviour: prefixes set flags, a final byte makes or breaks its key.
    task automatic model_byte(input logic [7:0] b, input bit bad);
        exp_t e;
        int code;
        code = 0;
        if (bad) begin
            e.is_err = 1'b1;
            e.code = 3'd0;
            exp_q.push_back(e);
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 7; i++) if (keys[i] == {m_ext, b}) code = i + 1;
            if (code != 0 && !m_brk) begin
                held = 3'(code);
                e.is_err = 1'b0;
                e.code = 3'(code);
                exp_q.push_back(e);
            end else if (code != 0 && held == 3'(code)) held = 3'd0;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask
    task automatic ps2_bit(input logic v);
        kbif.ps2_data = v;
        tick(HALF);
        kbif.ps2_clk = 1'b0;
        tick(HALF);
        kbif.ps2_clk = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        kbif.ps2_data = 1'b1;
        tick(GAP);
    endtask
    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_byte(b, bad_stop || (PAR_EN && bad_par));
        send_frame(b, bad_par, bad_stop, 11);
        @(negedge clk);
        check("held_code", kbif.keyboard_out, held);
    endtask
    always @(negedge clk) begin
        if (!rst && (kbif.key_valid || kbif.frame_error)) begin
            if (exp_q.size() == 0) check("unexpected_event", {kbif.key_valid, kbif.frame_error}, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_is_error", kbif.frame_error, e.is_err);
                if (!e.is_err) check("event_key_code", kbif.keyboard_out, e.code);
            end
        end
    end
    initial begin
        logic [7:0] b;
        kbif.ps2_clk = 1'b1;
        kbif.ps2_data = 1'b1;
        tick(5);
        rst = 1'b0;
        @(negedge clk);
        check("reset_keyboard_out", kbif.keyboard_out, 0);
        check("reset_key_valid", kbif.key_valid, 0);
        check("reset_frame_error", kbif.frame_error, 0);
        tick(10);
        frame(8'h5A, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'h72, 0, 0);
        frame(8'h29, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h72, 0, 0);
        frame(8'h5A, 1, 0);
        frame(8'h29, 0, 0);
        frame(8'h29, 0, 0);
        model_byte(8'h00, 1'b1);
        send_frame(8'h76, 0, 0, 5);
        tick(TMO + 100);
        @(negedge clk);
        check("timeout_drained", exp_q.size(), 0);
        frame(8'h76, 0, 0);
        send_frame(8'h29, 0, 0, 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        held = 3'd0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        @(negedge clk);
        check("midframe_reset_out", kbif.keyboard_out, 0);
        tick(GAP);
        frame(8'h5A, 0, 0);
        for (int g = 0; g < 5; g++) begin
            kbif.ps2_clk = 1'b0;
            tick(3);
            kbif.ps2_clk = 1'b1;
            tick(20);
        end
        @(negedge clk);
        check("glitch_no_change", kbif.keyboard_out, held);
        frame(8'h29, 0, 0);
        for (int n = 0; n < 45; n++) begin
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom);
            frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        tick(50);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
